// File: rtl/as_mem_ctrl_pkg.sv
// Shared opcodes, funct3 codes, FSM encoding and access-size helpers for the
// memory-access stage controller.
package as_mem_ctrl_pkg;

  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    AS_IDLE = 2'd0,
    AS_REQ  = 2'd1,
    AS_DONE = 2'd2
  } as_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Unknown funct3 codes fall back to a full-word access.
  function automatic acc_size_e access_size(input logic we, input logic [2:0] f3);
    acc_size_e sz;
    sz = SZ_W;
    if (we) begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        F3_SW:   sz = SZ_W;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        F3_LW:         sz = SZ_W;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      SZ_H:    mis = lo[0];
      SZ_W:    mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// and load data extraction with sign or zero extension.
module mem_lane_align
  import as_mem_ctrl_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    logic signed [7:0]  sv;
    logic signed [31:0] wide;
    sv   = v;
    wide = 32'(sv);
    return sgn ? wide : {24'h0, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    logic signed [15:0] sv;
    logic signed [31:0] wide;
    sv   = v;
    wide = 32'(sv);
    return sgn ? wide : {16'h0, v};
  endfunction

  logic [31:0] shifted;
  assign shifted = ld_word >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_LB:   ld_data = ext8(shifted[7:0], 1'b1);
      F3_LBU:  ld_data = ext8(shifted[7:0], 1'b0);
      F3_LH:   ld_data = ext16(shifted[15:0], 1'b1);
      F3_LHU:  ld_data = ext16(shifted[15:0], 1'b0);
      default: ld_data = ld_word;
    endcase
  end

  // Narrow stores replicate the datum into every lane; be selects the live one.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = st_data;
    case (access_size(1'b1, st_funct3))
      SZ_B: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/as_mem_ctrl.sv
// Memory-access stage controller: runs one req/ack bus transaction per load/store,
// stalls upstream while it is in flight, and passes other instructions straight through.
module as_mem_ctrl
  import as_mem_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acess_mem_flag_i,
  input  logic [31:0]          inst_i,
  input  logic [CPU_WIDTH-1:0] alu_res_i,
  input  logic [CPU_WIDTH-1:0] rs2_data_i,
  input  logic                 reg_wr_en_i,
  input  logic [4:0]           reg_wr_adder_i,
  output logic                 stall_o,
  output logic                 wb_en_o,
  output logic [4:0]           wb_adder_o,
  output logic [CPU_WIDTH-1:0] wb_data_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [CPU_WIDTH-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [CPU_WIDTH-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [CPU_WIDTH-1:0] mem_rdata_i,
  output logic                 misalign_o,
  output logic                 bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  as_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_p1;
  logic [2:0]     funct3_p1;
  logic [1:0]     addr_lo_p1;
  logic [4:0]     rd_p1;
  logic           wr_en_p1;
  logic           err_p1;
  logic [31:0]    rdata_p1;

  logic           in_we;
  logic [2:0]     in_funct3;
  logic           in_misalign;
  logic           timeout;
  logic [3:0]     st_be;
  logic [31:0]    st_wdata;
  logic [31:0]    ld_data;
  logic           unused_inst;

  assign in_we       = (inst_i[6:0] == INST_TYPE_S);
  assign in_funct3   = inst_i[14:12];
  assign in_misalign = misaligned(access_size(in_we, in_funct3), alu_res_i[1:0]);
  assign timeout     = (cnt_p1 == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

  mem_lane_align u_lane (
    .st_funct3  (in_funct3),
    .st_addr_lo (alu_res_i[1:0]),
    .st_data    (rs2_data_i),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (funct3_p1),
    .ld_addr_lo (addr_lo_p1),
    .ld_word    (rdata_p1),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= AS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    wb_en_o    = 1'b0;
    wb_adder_o = '0;
    wb_data_o  = '0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    case (state_q)
      AS_IDLE: begin
        if (acess_mem_flag_i) begin
          if (in_misalign) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = AS_REQ;
          end
        end else begin
          wb_en_o    = reg_wr_en_i;
          wb_adder_o = reg_wr_adder_i;
          wb_data_o  = alu_res_i;
        end
      end
      AS_REQ: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          state_d = AS_DONE;
        end else if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = AS_DONE;
        end
      end
      AS_DONE: begin
        wb_en_o    = wr_en_p1 & ~mem_we_o & ~err_p1;
        wb_adder_o = rd_p1;
        wb_data_o  = ld_data;
        state_d    = AS_IDLE;
      end
      default: state_d = AS_IDLE;
    endcase
    // Reset silences every combinational output, including the pulses.
    if (rst) begin
      state_d    = AS_IDLE;
      stall_o    = 1'b0;
      wb_en_o    = 1'b0;
      wb_adder_o = '0;
      wb_data_o  = '0;
      misalign_o = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

  // Stage boundary: request latched at IDLE exit, held through REQ, consumed in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1      <= '0;
      funct3_p1   <= '0;
      addr_lo_p1  <= '0;
      rd_p1       <= '0;
      wr_en_p1    <= 1'b0;
      err_p1      <= 1'b0;
      rdata_p1    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state_q)
        AS_IDLE: begin
          if (acess_mem_flag_i && !in_misalign) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= in_we;
            mem_addr_o  <= {alu_res_i[CPU_WIDTH-1:2], 2'b00};
            mem_be_o    <= in_we ? st_be : 4'hF;
            mem_wdata_o <= in_we ? st_wdata : '0;
            funct3_p1   <= in_funct3;
            addr_lo_p1  <= alu_res_i[1:0];
            rd_p1       <= reg_wr_adder_i;
            wr_en_p1    <= reg_wr_en_i;
            cnt_p1      <= '0;
            err_p1      <= 1'b0;
          end
        end
        AS_REQ: begin
          cnt_p1 <= cnt_p1 + 1'b1;
          if (mem_ack_i) begin
            rdata_p1  <= mem_rdata_i;
            mem_req_o <= 1'b0;
          end else if (timeout) begin
            mem_req_o <= 1'b0;
            err_p1    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_as_mem_ctrl.sv
// Bench for as_mem_ctrl: directed cases plus randomized load/store/ALU traffic
// checked against an arithmetic model of lane steering, extension and timing.
module tb_as_mem_ctrl;

  localparam int TO = 16;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk;
  logic        rst;
  logic        acess_mem_flag_i;
  logic [31:0] inst_i;
  logic [31:0] alu_res_i;
  logic [31:0] rs2_data_i;
  logic        reg_wr_en_i;
  logic [4:0]  reg_wr_adder_i;
  logic        stall_o;
  logic        wb_en_o;
  logic [4:0]  wb_adder_o;
  logic [31:0] wb_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        misalign_o;
  logic        bus_err_o;

  int n_vec = 0;
  int n_err = 0;

  as_mem_ctrl #(.CPU_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .acess_mem_flag_i (acess_mem_flag_i),
    .inst_i           (inst_i),
    .alu_res_i        (alu_res_i),
    .rs2_data_i       (rs2_data_i),
    .reg_wr_en_i      (reg_wr_en_i),
    .reg_wr_adder_i   (reg_wr_adder_i),
    .stall_o          (stall_o),
    .wb_en_o          (wb_en_o),
    .wb_adder_o       (wb_adder_o),
    .wb_data_o        (wb_data_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rdata_i      (mem_rdata_i),
    .misalign_o       (misalign_o),
    .bus_err_o        (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: access width in bytes, then lanes derived by plain arithmetic.
  function automatic int acc_bytes(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int     n;
    int     sh;
    longint v;
    longint span;
    n  = acc_bytes(1'b0, f3);
    sh = int'(addr % 4) * 8;
    v  = longint'(rdata >> sh);
    if (n < 4) begin
      span = longint'(1) << (8 * n);
      v = v % span;
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    int a;
    if (!st) return 4'hF;
    n = acc_bytes(1'b1, f3);
    a = int'(addr % 4);
    if (n == 1) return 4'(1 << a);
    if (n == 2) return (a == 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n;
    n = acc_bytes(1'b1, f3);
    if (n == 1) return rs2[7:0] * 32'h0101_0101;
    if (n == 2) return rs2[15:0] * 32'h0001_0001;
    return rs2;
  endfunction

  // Non-memory instruction; called at posedge+1, returns at the next posedge+1.
  task automatic pass_tx(input logic [31:0] alu, input logic [4:0] rd, input logic wen,
                         input logic ack);
    logic [31:0] r;
    r = $urandom();
    acess_mem_flag_i = 1'b0;
    inst_i           = {r[31:7], OP_ALU};
    alu_res_i        = alu;
    reg_wr_adder_i   = rd;
    reg_wr_en_i      = wen;
    mem_ack_i        = ack;
    @(negedge clk);
    chk("pass_wb_en", wb_en_o, wen);
    chk("pass_wb_adder", wb_adder_o, rd);
    chk("pass_wb_data", wb_data_o, alu);
    chk("pass_stall", stall_o, 1'b0);
    chk("pass_req", mem_req_o, 1'b0);
    chk("pass_pulses", {misalign_o, bus_err_o}, 2'b00);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
  endtask

  // Load/store; ack_at = REQ cycle carrying the ack (1-based), 0 = never ack.
  task automatic mem_tx(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int ack_at,
                        input logic [4:0] rd, input logic wen);
    int          n;
    bit          mis;
    bit          err;
    bit          acked;
    logic [31:0] r;
    n   = acc_bytes(st, f3);
    mis = (addr % n) != 0;
    r   = $urandom();
    acess_mem_flag_i = 1'b1;
    inst_i           = {r[31:15], f3, r[11:7], st ? OP_ST : OP_LD};
    alu_res_i        = addr;
    rs2_data_i       = rs2;
    reg_wr_en_i      = wen;
    reg_wr_adder_i   = rd;
    mem_ack_i        = 1'b0;
    @(negedge clk);
    if (mis) begin
      chk("mis_pulse", misalign_o, 1'b1);
      chk("mis_stall", stall_o, 1'b0);
      chk("mis_wb_en", wb_en_o, 1'b0);
      @(posedge clk); #1;
      acess_mem_flag_i = 1'b0;
      @(negedge clk);
      chk("mis_no_req", mem_req_o, 1'b0);
      chk("mis_pulse_end", misalign_o, 1'b0);
      @(posedge clk); #1;
      return;
    end
    chk("idle_stall", stall_o, 1'b1);
    chk("idle_wb_en", wb_en_o, 1'b0);
    chk("idle_mis", misalign_o, 1'b0);
    @(posedge clk); #1;
    alu_res_i      = $urandom();
    rs2_data_i     = $urandom();
    reg_wr_adder_i = 5'($urandom());
    err   = 1'b0;
    acked = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      mem_ack_i   = (k == ack_at);
      mem_rdata_i = (k == ack_at) ? rdata : $urandom();
      @(negedge clk);
      chk("req_stall", stall_o, 1'b1);
      chk("req_req", mem_req_o, 1'b1);
      chk("req_addr", mem_addr_o, {addr[31:2], 2'b00});
      chk("req_we", mem_we_o, st);
      chk("req_be", mem_be_o, exp_be(st, f3, addr));
      if (st) chk("req_wdata", mem_wdata_o, exp_wdata(f3, rs2));
      chk("req_bus_err", bus_err_o, (k != ack_at) && (k == TO));
      chk("req_mis", misalign_o, 1'b0);
      if (k == ack_at) acked = 1'b1;
      else if (k == TO) err = 1'b1;
      @(posedge clk); #1;
      if (acked || err) break;
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom();
    @(negedge clk);
    chk("done_stall", stall_o, 1'b0);
    chk("done_req", mem_req_o, 1'b0);
    chk("done_pulses", {misalign_o, bus_err_o}, 2'b00);
    chk("done_wb_en", wb_en_o, !st && !err && wen);
    if (!st && !err && wen) begin
      chk("done_wb_adder", wb_adder_o, rd);
      chk("done_wb_data", wb_data_o, exp_load(f3, addr, rdata));
    end
    @(posedge clk); #1;
    acess_mem_flag_i = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    acess_mem_flag_i = 1'b0;
    inst_i           = '0;
    alu_res_i        = '0;
    rs2_data_i       = '0;
    reg_wr_en_i      = 1'b0;
    reg_wr_adder_i   = '0;
    mem_ack_i        = 1'b0;
    mem_rdata_i      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_be_we", {mem_be_o, mem_we_o}, 5'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_pulses", {misalign_o, bus_err_o, wb_en_o}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;

    pass_tx(32'h0000_1234, 5'd5, 1'b1, 1'b0);
    mem_tx(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 2, 5'd7, 1'b1);
    mem_tx(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1, 5'd8, 1'b1);
    mem_tx(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h0, 1, 5'd9, 1'b1);
    mem_tx(1'b1, 3'b010, 32'h0000_4002, 32'h1111_2222, 32'h0, 1, 5'd10, 1'b1);
    mem_tx(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h0, 0, 5'd11, 1'b1);
    mem_tx(1'b0, 3'b010, 32'h0000_5008, 32'h0, 32'hCAFE_F00D, TO, 5'd12, 1'b1);
    mem_tx(1'b0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_1234, 3, 5'd13, 1'b1);
    mem_tx(1'b1, 3'b001, 32'h0000_7002, 32'h0000_5A3C, 32'h0, 2, 5'd14, 1'b0);
    pass_tx(32'hDEAD_BEEF, 5'd31, 1'b0, 1'b1);

    // Reset in the middle of a request.
    acess_mem_flag_i = 1'b1;
    inst_i           = {17'h0, 3'b010, 5'h0, OP_LD};
    alu_res_i        = 32'h0000_8000;
    reg_wr_en_i      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstreq_req", mem_req_o, 1'b1);
    @(posedge clk); #1;
    rst              = 1'b1;
    acess_mem_flag_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstreq_req_drop", mem_req_o, 1'b0);
    chk("rstreq_stall", stall_o, 1'b0);
    chk("rstreq_pulses", {misalign_o, bus_err_o}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    pass_tx(32'h0BAD_F00D, 5'd3, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          n;
      int          ack_at;
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom();
      n    = acc_bytes(st, f3);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
      case ($urandom_range(0, 9))
        0:       ack_at = 0;
        1:       ack_at = TO;
        default: ack_at = $urandom_range(1, 4);
      endcase
      mem_tx(st, f3, addr, $urandom(), $urandom(), ack_at, 5'($urandom()), 1'($urandom()));
      if ($urandom_range(0, 1) == 1)
        pass_tx($urandom(), 5'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
